// File: rtl/ras_spec_ctrl.sv
// ras_spec_ctrl
//
// Speculation controller between fetch-stage call/return decode and a
// 16-entry return address stack (RAS). Every speculative stack operation
// is recorded in an undo log. Commits retire the oldest entry. A flush
// unwinds the uncommitted entries youngest-first with compensating stack
// operations, which puts the stack back in its committed state.
//
// Ports
//   clk               clock
//   reset             asynchronous active-high reset
//   call_valid_i      fetch decoded a call this cycle
//   call_ret_addr_i   return address of that call
//   ret_valid_i       fetch decoded a return this cycle
//   ras_pop_addr_i    current top of stack (combinational from the stack)
//   ras_empty_i       stack empty flag
//   commit_i          oldest logged op resolved on the correct path
//   flush_i           mispredict, discard all uncommitted ops
//   ras_push_o        push strobe to the stack
//   ras_push_addr_o   push data
//   ras_pop_o         pop strobe to the stack
//   pred_ret_valid_o  return prediction valid
//   pred_ret_addr_o   predicted return target
//   ready_o           call/ret can be accepted this cycle
//   recovering_o      undo sequence in progress
//   log_count_o       occupied undo-log entries
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accept call/ret, log them, retire on commit
//   UNDO    | replay one compensating op per cycle, youngest entry first

module ras_spec_ctrl #(
    parameter int LOG_DEPTH = 8,
    parameter int ADDR_W    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         call_valid_i,
    input  logic [ADDR_W-1:0]            call_ret_addr_i,
    input  logic                         ret_valid_i,
    input  logic [ADDR_W-1:0]            ras_pop_addr_i,
    input  logic                         ras_empty_i,
    input  logic                         commit_i,
    input  logic                         flush_i,
    output logic                         ras_push_o,
    output logic [ADDR_W-1:0]            ras_push_addr_o,
    output logic                         ras_pop_o,
    output logic                         pred_ret_valid_o,
    output logic [ADDR_W-1:0]            pred_ret_addr_o,
    output logic                         ready_o,
    output logic                         recovering_o,
    output logic [$clog2(LOG_DEPTH):0]   log_count_o
);

    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_UNDO = 1'b1;

    // Entry kind: what the speculative op did to the stack
    localparam logic KIND_POP  = 1'b0;
    localparam logic KIND_PUSH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              armed_q;

    logic              log_kind_q [LOG_DEPTH];
    logic [ADDR_W-1:0] log_addr_q [LOG_DEPTH];

    logic              is_idle;
    logic              is_undo;
    logic              accept_call;
    logic              accept_ret;
    logic              append;
    logic              retire;
    logic [PW-1:0]     undo_idx;
    logic              undo_kind;
    logic [ADDR_W-1:0] undo_addr;
    logic [CW-1:0]     count_after_retire;

    // armed_q keeps ready_o low during reset and for the first cycle after
    // release, so every output is zero until the controller has seen a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        is_idle = (state_q == ST_IDLE);
        is_undo = (state_q == ST_UNDO);
        ready_o = armed_q && is_idle && (count_q < CW'(LOG_DEPTH));

        // A flush cancels anything fetch presents in the same cycle. A call
        // takes priority over a simultaneous return.
        accept_call = ready_o && call_valid_i && !flush_i;
        accept_ret  = ready_o && ret_valid_i && !call_valid_i &&
                      !ras_empty_i && !flush_i;
        append      = accept_call || accept_ret;
        retire      = is_idle && commit_i && (count_q != '0);

        undo_idx  = tail_q - PW'(1);
        undo_kind = log_kind_q[undo_idx];
        undo_addr = log_addr_q[undo_idx];
    end

    always_comb begin
        ras_push_o       = 1'b0;
        ras_push_addr_o  = '0;
        ras_pop_o        = 1'b0;
        pred_ret_valid_o = 1'b0;
        pred_ret_addr_o  = '0;
        recovering_o     = is_undo;
        log_count_o      = count_q;

        if (is_undo) begin
            // Compensate the youngest entry: a logged push is undone by a pop,
            // a logged pop is undone by pushing back the address it removed.
            if (undo_kind == KIND_PUSH) begin
                ras_pop_o = 1'b1;
            end else begin
                ras_push_o      = 1'b1;
                ras_push_addr_o = undo_addr;
            end
        end else if (accept_call) begin
            ras_push_o      = 1'b1;
            ras_push_addr_o = call_ret_addr_i;
        end else if (accept_ret) begin
            ras_pop_o        = 1'b1;
            pred_ret_valid_o = 1'b1;
            pred_ret_addr_o  = ras_pop_addr_i;
        end
    end

    always_comb begin
        state_d            = state_q;
        head_d             = head_q;
        tail_d             = tail_q;
        count_d            = count_q;
        count_after_retire = count_q - CW'(retire);

        if (is_idle) begin
            if (append) begin
                tail_d = tail_q + PW'(1);
            end
            if (retire) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_after_retire + CW'(append);
            // Commit in the flush cycle is applied before deciding whether
            // anything is left to unwind.
            if (flush_i && (count_after_retire != '0)) begin
                state_d = ST_UNDO;
            end
        end else begin
            tail_d  = tail_q - PW'(1);
            count_d = count_q - CW'(1);
            if (count_q <= CW'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Log payload needs no reset: entries are only read below a valid count.
    always_ff @(posedge clk) begin
        if (append) begin
            log_kind_q[tail_q] <= accept_call ? KIND_PUSH : KIND_POP;
            log_addr_q[tail_q] <= accept_call ? call_ret_addr_i : ras_pop_addr_i;
        end
    end

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// tb_ras_spec_ctrl
//
// Directed bench for ras_spec_ctrl. A small saturating 16-entry stack
// model sits on the stack side of the DUT so that pop address and empty
// flag follow the strobes the controller issues.

module tb_ras_spec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_valid_i;
    logic [63:0] call_ret_addr_i;
    logic        ret_valid_i;
    logic [63:0] ras_pop_addr_i;
    logic        ras_empty_i;
    logic        commit_i;
    logic        flush_i;
    logic        ras_push_o;
    logic [63:0] ras_push_addr_o;
    logic        ras_pop_o;
    logic        pred_ret_valid_o;
    logic [63:0] pred_ret_addr_o;
    logic        ready_o;
    logic        recovering_o;
    logic [3:0]  log_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_spec_ctrl #(.LOG_DEPTH(8), .ADDR_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .call_valid_i     (call_valid_i),
        .call_ret_addr_i  (call_ret_addr_i),
        .ret_valid_i      (ret_valid_i),
        .ras_pop_addr_i   (ras_pop_addr_i),
        .ras_empty_i      (ras_empty_i),
        .commit_i         (commit_i),
        .flush_i          (flush_i),
        .ras_push_o       (ras_push_o),
        .ras_push_addr_o  (ras_push_addr_o),
        .ras_pop_o        (ras_pop_o),
        .pred_ret_valid_o (pred_ret_valid_o),
        .pred_ret_addr_o  (pred_ret_addr_o),
        .ready_o          (ready_o),
        .recovering_o     (recovering_o),
        .log_count_o      (log_count_o)
    );

    // Stack model: saturates at 16, reset together with the controller.
    logic [63:0] stk [16];
    logic [4:0]  depth;
    logic [3:0]  top_idx;

    assign top_idx        = depth[3:0] - 4'd1;
    assign ras_empty_i    = (depth == 5'd0);
    assign ras_pop_addr_i = ras_empty_i ? 64'd0 : stk[top_idx];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= 5'd0;
        end else if (ras_push_o) begin
            if (depth < 5'd16) begin
                stk[depth[3:0]] <= ras_push_addr_o;
                depth           <= depth + 5'd1;
            end
        end else if (ras_pop_o && depth != 5'd0) begin
            depth <= depth - 5'd1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(call_valid_i && ret_valid_i))
                else $error("protocol violation: call and ret together");
            assert (!(ras_push_o && ras_pop_o))
                else $error("push and pop strobes together");
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // call 0x1000, call 0x2000, ret: leaves stack [0x1000] and 3 log entries
    task automatic seq_call_call_ret(input string pfx);
        call_valid_i    = 1'b1;
        call_ret_addr_i = 64'h1000;
        #1;
        chk({pfx, "_push1"}, 64'(ras_push_o), 64'd1);
        chk({pfx, "_push1_addr"}, ras_push_addr_o, 64'h1000);
        step();
        call_ret_addr_i = 64'h2000;
        #1;
        chk({pfx, "_push2_addr"}, ras_push_addr_o, 64'h2000);
        step();
        call_valid_i    = 1'b0;
        call_ret_addr_i = 64'd0;
        ret_valid_i     = 1'b1;
        #1;
        chk({pfx, "_ret_pop"}, 64'(ras_pop_o), 64'd1);
        chk({pfx, "_ret_pred_v"}, 64'(pred_ret_valid_o), 64'd1);
        chk({pfx, "_ret_pred_addr"}, pred_ret_addr_o, 64'h2000);
        chk({pfx, "_ret_nopush"}, 64'(ras_push_o), 64'd0);
        step();
        ret_valid_i = 1'b0;
        #1;
        chk({pfx, "_count3"}, 64'(log_count_o), 64'd3);
        chk({pfx, "_depth1"}, 64'(depth), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        call_valid_i    = 1'b0;
        call_ret_addr_i = 64'd0;
        ret_valid_i     = 1'b0;
        commit_i        = 1'b0;
        flush_i         = 1'b0;

        // 1. reset behaviour
        #2;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_count", 64'(log_count_o), 64'd0);
        chk("rst_rec", 64'(recovering_o), 64'd0);
        #10;
        reset = 1'b0;
        #1;
        chk("rel_ready", 64'(ready_o), 64'd0);
        repeat (5) step();
        chk("idle_ready", 64'(ready_o), 64'd1);
        chk("idle_count", 64'(log_count_o), 64'd0);
        chk("idle_push", 64'(ras_push_o), 64'd0);
        chk("idle_pop", 64'(ras_pop_o), 64'd0);
        chk("idle_pred", 64'(pred_ret_valid_o), 64'd0);
        chk("idle_rec", 64'(recovering_o), 64'd0);

        // ret on an empty stack: no pop, no prediction, no log entry
        ret_valid_i = 1'b1;
        #1;
        chk("empty_ret_pop", 64'(ras_pop_o), 64'd0);
        chk("empty_ret_pred", 64'(pred_ret_valid_o), 64'd0);
        step();
        ret_valid_i = 1'b0;
        #1;
        chk("empty_ret_count", 64'(log_count_o), 64'd0);

        // 2. call, call, ret
        seq_call_call_ret("t2");

        // 3. flush unwinds all three entries
        flush_i = 1'b1;
        #1;
        chk("t3_flushcyc_rec", 64'(recovering_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1;
        chk("t3_u1_rec", 64'(recovering_o), 64'd1);
        chk("t3_u1_ready", 64'(ready_o), 64'd0);
        chk("t3_u1_push", 64'(ras_push_o), 64'd1);
        chk("t3_u1_addr", ras_push_addr_o, 64'h2000);
        chk("t3_u1_pred", 64'(pred_ret_valid_o), 64'd0);
        step();
        chk("t3_u2_rec", 64'(recovering_o), 64'd1);
        chk("t3_u2_pop", 64'(ras_pop_o), 64'd1);
        chk("t3_u2_push", 64'(ras_push_o), 64'd0);
        step();
        chk("t3_u3_pop", 64'(ras_pop_o), 64'd1);
        step();
        chk("t3_end_rec", 64'(recovering_o), 64'd0);
        chk("t3_end_ready", 64'(ready_o), 64'd1);
        chk("t3_end_count", 64'(log_count_o), 64'd0);
        chk("t3_end_depth", 64'(depth), 64'd0);

        // 4. commit the two calls, flush: only the ret is undone. The
        //    committed state holds both calls, so the top becomes 0x2000.
        seq_call_call_ret("t4");
        commit_i = 1'b1;
        step();
        step();
        commit_i = 1'b0;
        #1;
        chk("t4_count1", 64'(log_count_o), 64'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        chk("t4_u1_rec", 64'(recovering_o), 64'd1);
        chk("t4_u1_addr", ras_push_addr_o, 64'h2000);
        step();
        chk("t4_end_rec", 64'(recovering_o), 64'd0);
        chk("t4_end_depth", 64'(depth), 64'd2);
        chk("t4_end_top", ras_pop_addr_i, 64'h2000);

        // 5. fill the log with eight calls
        for (int i = 0; i < 8; i++) begin
            call_valid_i    = 1'b1;
            call_ret_addr_i = 64'h3000 + 64'(i * 16);
            step();
        end
        call_ret_addr_i = 64'h3080;
        #1;
        chk("t5_full_ready", 64'(ready_o), 64'd0);
        chk("t5_full_count", 64'(log_count_o), 64'd8);
        chk("t5_9th_push", 64'(ras_push_o), 64'd0);
        step();
        chk("t5_9th_count", 64'(log_count_o), 64'd8);
        chk("t5_depth", 64'(depth), 64'd10);
        commit_i = 1'b1;
        #1;
        chk("t5_commit_push", 64'(ras_push_o), 64'd0);
        step();
        commit_i     = 1'b0;
        call_valid_i = 1'b0;
        #1;
        chk("t5_after_ready", 64'(ready_o), 64'd1);
        chk("t5_after_count", 64'(log_count_o), 64'd7);

        // 6a. flush together with the commit of the last entry: no UNDO
        commit_i = 1'b1;
        repeat (6) step();
        commit_i = 1'b0;
        #1;
        chk("t6_count1", 64'(log_count_o), 64'd1);
        commit_i = 1'b1;
        flush_i  = 1'b1;
        #1;
        chk("t6_cf_rec", 64'(recovering_o), 64'd0);
        step();
        commit_i = 1'b0;
        flush_i  = 1'b0;
        #1;
        chk("t6_cf_rec_after", 64'(recovering_o), 64'd0);
        chk("t6_cf_count", 64'(log_count_o), 64'd0);
        chk("t6_cf_ready", 64'(ready_o), 64'd1);
        chk("t6_cf_depth", 64'(depth), 64'd10);

        // 6b. reset in the middle of an undo sequence
        call_valid_i    = 1'b1;
        call_ret_addr_i = 64'hA;
        step();
        call_ret_addr_i = 64'hB;
        step();
        call_ret_addr_i = 64'hC;
        flush_i         = 1'b1;
        #1;
        chk("t6_flush_drops_call", 64'(ras_push_o), 64'd0);
        step();
        call_valid_i = 1'b0;
        flush_i      = 1'b0;
        #1;
        chk("t6_u1_rec", 64'(recovering_o), 64'd1);
        chk("t6_u1_pop", 64'(ras_pop_o), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_rec", 64'(recovering_o), 64'd0);
        chk("t6_rst_pop", 64'(ras_pop_o), 64'd0);
        chk("t6_rst_push", 64'(ras_push_o), 64'd0);
        chk("t6_rst_ready", 64'(ready_o), 64'd0);
        chk("t6_rst_count", 64'(log_count_o), 64'd0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("t6_post_ready", 64'(ready_o), 64'd1);
        chk("t6_post_rec", 64'(recovering_o), 64'd0);
        chk("t6_post_count", 64'(log_count_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
